frame_warper_pipe: RTL
======================

Name: frame_warper_pipe

Overview:
- Parametrised successor to the first-generation frame warper.
- Raster-scans an output frame, reads per-pixel flow (u,v), and samples the source frame at (x+u, y+v) with bilinear interpolation.
- Writes the warped frame to destination BRAM.
- Adds configurable fixed-point fraction width, selectable border handling (zero or clamp), round-to-nearest, a registered MAC, a busy flag and a registered done pulse.

Parameters:
PIXEL_WIDTH, 8, pixel bits (unsigned)
FLOW_WIDTH, 16, signed flow component bits
FRAC_BITS, 7, fractional bits of flow (S(FLOW_WIDTH-1-FRAC_BITS).FRAC_BITS)
WIDTH, 160, frame width in pixels (>=2)
HEIGHT, 120, frame height in pixels (>=2)
ADDR_WIDTH, 17, BRAM address bits (>= clog2(WIDTH*HEIGHT))

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin a frame; sampled only in IDLE
border_mode  in  1  0 = zero outside frame, 1 = clamp to edge; latched on start
busy  out  1  high while a frame is in progress
done  out  1  one-cycle pulse after the last pixel write
src_pixel_data  in  PIXEL_WIDTH  source BRAM read data
src_addr  out  ADDR_WIDTH  source read address
src_re  out  1  source read enable
flow_u_data  in  FLOW_WIDTH  signed u
flow_v_data  in  FLOW_WIDTH  signed v
flow_addr  out  ADDR_WIDTH  flow read address
flow_re  out  1  flow read enable
warped_pixel_data  out  PIXEL_WIDTH  output pixel
warped_addr  out  ADDR_WIDTH  output address
warped_we  out  1  output write strobe

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous, active-low, and is the only reset.
- Reset values: all outputs are 0, the FSM is in IDLE, and the counters are 0. Reset mid-frame aborts immediately, with no further writes and no done pulse.
- Output registering: all outputs are registered. BRAM read latency is 1 cycle after the registered address/enable becomes visible, so read data is sampled 2 states after the state that issued the read.
- FSM per pixel (12 cycles):
  - FLOW_RD: issue flow_addr = y*WIDTH + x, flow_re = 1.
  - FLOW_WAIT.
  - COORD: capture u and v. Compute sx = (x<<FRAC_BITS) + u and sy likewise, in FLOW_WIDTH+2 signed bits. Derive x0 = sx>>>FRAC_BITS (floor), x1 = x0+1, wx = sx[FRAC_BITS-1:0], and the same for y0, y1, wy.
  - RD0..RD3: issue corner reads in order f00 (x0,y0), f10 (x1,y0), f01 (x0,y1), f11 (x1,y1).
  - Corner capture: f00 in RD2, f10 in RD3, f01 in CAP_A, f11 in CAP_B.
  - MAC: register the four products (W-wx)(W-wy)f00, wx(W-wy)f10, (W-wx)wy f01, wx·wy f11, where W = 1<<FRAC_BITS.
  - SUM: compute (sum + (1<<(2*FRAC_BITS-1))) >> (2*FRAC_BITS). Saturate to 2^PIXEL_WIDTH-1. Accumulator width is PIXEL_WIDTH+2*FRAC_BITS+2.
  - WRITE: warped_addr = y*WIDTH + x, warped_we = 1 for exactly one cycle. Advance x, wrap to 0 and increment y at WIDTH-1. After (WIDTH-1, HEIGHT-1) go to IDLE.
- Border handling, per corner:
  - Zero mode: a corner outside [0,WIDTH-1]×[0,HEIGHT-1] issues no read (src_re = 0 that cycle), and its captured value is forced to 0.
  - Clamp mode: each corner coordinate is clamped into range before address generation; src_re = 1 always.
- Pixel timing: per-pixel latency is 12 cycles, so a frame takes 12·WIDTH·HEIGHT cycles after start (230400 at the defaults).
- busy and done:
  - busy goes high the cycle after start is accepted.
  - done pulses 1 cycle, in the cycle after the final WRITE, coincident with busy falling.
  - start while busy is ignored. start in the same cycle as done is not accepted; start is accepted the following cycle.
- Bus exclusivity: only one of flow_re, src_re or warped_we is asserted in any cycle.

Test Plan:
1. Zero flow, ramp source pix = (x+y)&255, border_mode = 0 -> output equals source exactly. One warped_we per address 0..19199, done at cycle 230400 after start, busy low afterwards.
2. u = +64 (0.5 px), v = 0, source pix = 2x -> interior outputs 2x+1. Column 159 outputs round(0.5·f00) (f10 zeroed) in mode 0, and f00 in mode 1.
3. u = -128 (-1 px), v = -128, border_mode = 0 -> row 0 and column 0 write 0 with no src_re for those corners. Interior pixel (x,y) equals src(x-1,y-1).
4. Rounding check with wx = wy = 64, corners 0, 0, 0, 1 -> result round(0.25) = 0. With corners 1, 1, 1, 2 -> round(1.25) = 1. With all corners 255 -> 255, with no overflow.
5. Large flow u = +32767, mode 1 -> clamped to column 159, output = src(159,y), no address ≥ 19200 issued. Same input in mode 0 -> output 0.
6. Assert rst_n low at pixel 500 mid-MAC for 1 cycle -> all outputs 0 the next cycle, no done. A fresh start then produces a full frame matching scenario 1.

Source files
------------

// File: rtl/frame_warper_pipe.sv
// frame_warper_pipe: raster-scans an output frame, fetches per-pixel flow
// (u,v) and bilinearly samples the source frame at (x+u, y+v).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, border_mode  frame request; 0 = zero outside, 1 = clamp (latched)
//   busy, done          frame in progress; one-cycle completion pulse
//   src_*               source BRAM read port (1-cycle latency)
//   flow_*              flow BRAM read port (signed u, v)
//   warped_*            destination BRAM write port
module frame_warper_pipe #(
    parameter int PIXEL_WIDTH = 8,
    parameter int FLOW_WIDTH  = 16,
    parameter int FRAC_BITS   = 7,
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 120,
    parameter int ADDR_WIDTH  = 17
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         border_mode,
    output logic                         busy,
    output logic                         done,
    input  logic [PIXEL_WIDTH-1:0]       src_pixel_data,
    output logic [ADDR_WIDTH-1:0]        src_addr,
    output logic                         src_re,
    input  logic signed [FLOW_WIDTH-1:0] flow_u_data,
    input  logic signed [FLOW_WIDTH-1:0] flow_v_data,
    output logic [ADDR_WIDTH-1:0]        flow_addr,
    output logic                         flow_re,
    output logic [PIXEL_WIDTH-1:0]       warped_pixel_data,
    output logic [ADDR_WIDTH-1:0]        warped_addr,
    output logic                         warped_we
);

    typedef enum logic [3:0] {
        S_IDLE, S_FLOW_RD, S_FLOW_WAIT, S_COORD,
        S_RD0, S_RD1, S_RD2, S_RD3,
        S_CAP_A, S_CAP_B, S_MAC, S_SUM, S_WRITE
    } state_t;

    localparam int SW    = FLOW_WIDTH + 2;
    localparam int ACC_W = PIXEL_WIDTH + 2*FRAC_BITS + 2;
    localparam int XW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic signed [SW-1:0] XMAX = SW'(WIDTH - 1);
    localparam logic signed [SW-1:0] YMAX = SW'(HEIGHT - 1);
    localparam logic [XW-1:0] XLAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YLAST = YW'(HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW = ADDR_WIDTH'(WIDTH);
    localparam logic [FRAC_BITS:0] WONE = {1'b1, {FRAC_BITS{1'b0}}};
    localparam logic [ACC_W-1:0] RND = ACC_W'(1) << (2*FRAC_BITS - 1);
    localparam logic [ACC_W-1:0] PMAX = ACC_W'((1 << PIXEL_WIDTH) - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic [ADDR_WIDTH-1:0] r_pix;
    logic                  r_mode;

    logic signed [SW-1:0]  r_x0, r_x1, r_y0, r_y1;
    logic [FRAC_BITS-1:0]  r_wx, r_wy;
    logic [PIXEL_WIDTH-1:0] r_f00, r_f10, r_f01, r_f11;
    logic [ACC_W-1:0]      r_p0, r_p1, r_p2, r_p3;
    logic [PIXEL_WIDTH-1:0] r_result;

    logic                   r_busy, r_done;
    logic [ADDR_WIDTH-1:0]  r_src_addr, r_flow_addr, r_waddr;
    logic                   r_src_re, r_flow_re, r_we;
    logic [PIXEL_WIDTH-1:0] r_wdata;

    logic                  w_accept, w_last, w_rd;
    logic                  w_flow_re, w_src_re, w_we;
    logic signed [SW-1:0]  w_sx, w_sy, w_x0, w_y0;
    logic signed [SW-1:0]  w_cx, w_cy;
    logic                  w_c_ok;
    logic [ADDR_WIDTH-1:0] w_src_addr;
    logic                  w_ok00, w_ok10, w_ok01, w_ok11;
    logic [FRAC_BITS:0]    w_iwx, w_iwy, w_wx, w_wy;
    logic [ACC_W-1:0]      w_acc, w_shr;
    logic [PIXEL_WIDTH-1:0] w_sat;

    function automatic logic in_rng(
        input logic signed [SW-1:0] c,
        input logic signed [SW-1:0] hi
    );
        return !c[SW-1] && (c <= hi);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] clamp(
        input logic signed [SW-1:0] c,
        input logic signed [SW-1:0] hi
    );
        logic signed [SW-1:0] t;
        if (c[SW-1])      t = '0;
        else if (c > hi)  t = hi;
        else              t = c;
        return ADDR_WIDTH'(t);
    endfunction

    // A start coinciding with the done pulse is deliberately dropped.
    assign w_accept = (r_state == S_IDLE) && start && !r_done;
    assign w_last   = (r_x == XLAST) && (r_y == YLAST);
    assign w_rd     = r_state inside {S_RD0, S_RD1, S_RD2, S_RD3};

    // Source position in fixed point; floor via arithmetic shift.
    assign w_sx = $signed(SW'(r_x) << FRAC_BITS) + SW'(flow_u_data);
    assign w_sy = $signed(SW'(r_y) << FRAC_BITS) + SW'(flow_v_data);
    assign w_x0 = w_sx >>> FRAC_BITS;
    assign w_y0 = w_sy >>> FRAC_BITS;

    // Corner being read this cycle: RD0 f00, RD1 f10, RD2 f01, RD3 f11.
    always_comb begin
        w_cx = r_x0;
        w_cy = r_y0;
        if (r_state == S_RD1 || r_state == S_RD3) w_cx = r_x1;
        if (r_state == S_RD2 || r_state == S_RD3) w_cy = r_y1;
    end

    assign w_c_ok = in_rng(w_cx, XMAX) && in_rng(w_cy, YMAX);
    // Address always uses clamped coordinates so it never leaves the frame.
    assign w_src_addr = clamp(w_cy, YMAX) * ROW + clamp(w_cx, XMAX);

    assign w_ok00 = r_mode || (in_rng(r_x0, XMAX) && in_rng(r_y0, YMAX));
    assign w_ok10 = r_mode || (in_rng(r_x1, XMAX) && in_rng(r_y0, YMAX));
    assign w_ok01 = r_mode || (in_rng(r_x0, XMAX) && in_rng(r_y1, YMAX));
    assign w_ok11 = r_mode || (in_rng(r_x1, XMAX) && in_rng(r_y1, YMAX));

    assign w_wx  = {1'b0, r_wx};
    assign w_wy  = {1'b0, r_wy};
    assign w_iwx = WONE - w_wx;
    assign w_iwy = WONE - w_wy;

    assign w_acc = r_p0 + r_p1 + r_p2 + r_p3 + RND;
    assign w_shr = w_acc >> (2*FRAC_BITS);
    assign w_sat = (w_shr > PMAX) ? PIXEL_WIDTH'(PMAX)
                                  : PIXEL_WIDTH'(w_shr);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_flow_re   = 1'b0;
        w_src_re    = 1'b0;
        w_we        = 1'b0;
        unique case (r_state)
            S_IDLE:      if (w_accept) w_state_nxt = S_FLOW_RD;
            S_FLOW_RD: begin
                w_flow_re   = 1'b1;
                w_state_nxt = S_FLOW_WAIT;
            end
            S_FLOW_WAIT: w_state_nxt = S_COORD;
            S_COORD:     w_state_nxt = S_RD0;
            S_RD0: begin
                w_src_re    = r_mode || w_c_ok;
                w_state_nxt = S_RD1;
            end
            S_RD1: begin
                w_src_re    = r_mode || w_c_ok;
                w_state_nxt = S_RD2;
            end
            S_RD2: begin
                w_src_re    = r_mode || w_c_ok;
                w_state_nxt = S_RD3;
            end
            S_RD3: begin
                w_src_re    = r_mode || w_c_ok;
                w_state_nxt = S_CAP_A;
            end
            S_CAP_A:     w_state_nxt = S_CAP_B;
            S_CAP_B:     w_state_nxt = S_MAC;
            S_MAC:       w_state_nxt = S_SUM;
            S_SUM:       w_state_nxt = S_WRITE;
            S_WRITE: begin
                w_we        = 1'b1;
                w_state_nxt = w_last ? S_IDLE : S_FLOW_RD;
            end
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_flow_re   <= 1'b0;
            r_flow_addr <= '0;
            r_src_re    <= 1'b0;
            r_src_addr  <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
        end else begin
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (r_state == S_WRITE) && w_last;
            r_flow_re <= w_flow_re;
            r_src_re  <= w_src_re;
            r_we      <= w_we;
            if (w_flow_re) r_flow_addr <= r_pix;
            if (w_rd)      r_src_addr  <= w_src_addr;
            if (w_we) begin
                r_waddr <= r_pix;
                r_wdata <= r_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_pix  <= '0;
            r_mode <= 1'b0;
        end else begin
            if (w_accept) r_mode <= border_mode;
            if (r_state == S_WRITE) begin
                if (w_last) begin
                    r_x   <= '0;
                    r_y   <= '0;
                    r_pix <= '0;
                end else begin
                    r_pix <= r_pix + ADDR_WIDTH'(1);
                    if (r_x == XLAST) begin
                        r_x <= '0;
                        r_y <= r_y + YW'(1);
                    end else begin
                        r_x <= r_x + XW'(1);
                    end
                end
            end
        end
    end

    // Datapath: captures follow the 2-state read latency of each corner.
    always_ff @(posedge clk) begin
        if (r_state == S_COORD) begin
            r_x0 <= w_x0;
            r_x1 <= w_x0 + SW'(1);
            r_y0 <= w_y0;
            r_y1 <= w_y0 + SW'(1);
            r_wx <= w_sx[FRAC_BITS-1:0];
            r_wy <= w_sy[FRAC_BITS-1:0];
        end
        if (r_state == S_RD2)   r_f00 <= w_ok00 ? src_pixel_data : '0;
        if (r_state == S_RD3)   r_f10 <= w_ok10 ? src_pixel_data : '0;
        if (r_state == S_CAP_A) r_f01 <= w_ok01 ? src_pixel_data : '0;
        if (r_state == S_CAP_B) r_f11 <= w_ok11 ? src_pixel_data : '0;
        if (r_state == S_MAC) begin
            r_p0 <= ACC_W'(w_iwx) * ACC_W'(w_iwy) * ACC_W'(r_f00);
            r_p1 <= ACC_W'(w_wx)  * ACC_W'(w_iwy) * ACC_W'(r_f10);
            r_p2 <= ACC_W'(w_iwx) * ACC_W'(w_wy)  * ACC_W'(r_f01);
            r_p3 <= ACC_W'(w_wx)  * ACC_W'(w_wy)  * ACC_W'(r_f11);
        end
        if (r_state == S_SUM) r_result <= w_sat;
    end

    assign busy              = r_busy;
    assign done              = r_done;
    assign flow_re           = r_flow_re;
    assign flow_addr         = r_flow_addr;
    assign src_re            = r_src_re;
    assign src_addr          = r_src_addr;
    assign warped_we         = r_we;
    assign warped_addr       = r_waddr;
    assign warped_pixel_data = r_wdata;

endmodule
